// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - default 640x480@60 timing, pattern mode encoding and colour-bar helper
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int OFFSET_W = 11;

    typedef enum logic [1:0] {
        MODE_SOLID   = 2'd0,
        MODE_CHECKER = 2'd1,
        MODE_BARS    = 2'd2,
        MODE_SCROLL  = 2'd3
    } mode_e;

    // Eight equal bars across the active line; comparators avoid a divider.
    function automatic logic [2:0] bar_index(input logic [15:0] h, input logic [15:0] bar_w);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (h >= 16'(i) * bar_w) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// rtl/vga_pattern_gen_if.sv - pattern control inputs and video outputs of the generator
interface vga_pattern_gen_if #(
    parameter int COLOR_BITS = 2
);
    logic [1:0]            mode;
    logic [3:0]            speed;
    logic                  hsync;
    logic                  vsync;
    logic [COLOR_BITS-1:0] red;
    logic [COLOR_BITS-1:0] green;
    logic [COLOR_BITS-1:0] blue;
    logic                  de;
    logic                  frame_start;

    modport master (
        output mode, speed,
        input  hsync, vsync, red, green, blue, de, frame_start
    );

    modport slave (
        input  mode, speed,
        output hsync, vsync, red, green, blue, de, frame_start
    );
endinterface

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - h/v counters plus registered sync, de and frame_start generation
module vga_timing #(
    parameter int H_ACTIVE        = 640,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int HW              = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int VW              = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [HW-1:0] o_h_cnt,
    output logic [VW-1:0] o_v_cnt,
    output logic          o_active,
    output logic          o_frame_origin,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_de,
    output logic          o_frame_start
);
    localparam int   H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int   V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_de;
    logic          r_frame_start;

    logic w_h_last;
    logic w_v_last;
    logic w_hs_act;
    logic w_vs_act;
    logic w_active;
    logic w_origin;

    assign w_h_last = (r_h_cnt == HW'(H_TOTAL - 1));
    assign w_v_last = (r_v_cnt == VW'(V_TOTAL - 1));
    assign w_hs_act = (r_h_cnt >= HW'(H_ACTIVE + H_FP)) && (r_h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
    assign w_vs_act = (r_v_cnt >= VW'(V_ACTIVE + V_FP)) && (r_v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));
    assign w_active = (r_h_cnt < HW'(H_ACTIVE)) && (r_v_cnt < VW'(V_ACTIVE));
    assign w_origin = (r_h_cnt == '0) && (r_v_cnt == '0);

    // Sync outputs are the active flag flipped by the idle level, so one XOR covers both polarities.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_hsync       <= SYNC_IDLE;
            r_vsync       <= SYNC_IDLE;
            r_de          <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + VW'(1);
            end else begin
                r_h_cnt <= r_h_cnt + HW'(1);
            end
            r_hsync       <= w_hs_act ^ SYNC_IDLE;
            r_vsync       <= w_vs_act ^ SYNC_IDLE;
            r_de          <= w_active;
            r_frame_start <= w_origin;
        end
    end

    assign o_h_cnt        = r_h_cnt;
    assign o_v_cnt        = r_v_cnt;
    assign o_active       = w_active;
    assign o_frame_origin = w_origin;
    assign o_hsync        = r_hsync;
    assign o_vsync        = r_vsync;
    assign o_de           = r_de;
    assign o_frame_start  = r_frame_start;
endmodule

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - VGA test pattern generator; VGA_PATTERN_BORDER_EN adds a max-colour frame border
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE        = DEF_H_ACTIVE,
    parameter int H_FP            = DEF_H_FP,
    parameter int H_SYNC          = DEF_H_SYNC,
    parameter int H_BP            = DEF_H_BP,
    parameter int V_ACTIVE        = DEF_V_ACTIVE,
    parameter int V_FP            = DEF_V_FP,
    parameter int V_SYNC          = DEF_V_SYNC,
    parameter int V_BP            = DEF_V_BP,
    parameter int COLOR_BITS      = 2,
    parameter int TILE_LOG2       = 5,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input logic              clk,
    input logic              rst,
    vga_pattern_gen_if.slave vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam logic [COLOR_BITS-1:0] C_MAX = '1;

    logic [HW-1:0] w_h_cnt;
    logic [VW-1:0] w_v_cnt;
    logic          w_active;
    logic          w_origin;

    mode_e                r_mode;
    mode_e                w_mode;
    logic [3:0]           r_speed;
    logic [3:0]           w_speed;
    logic [OFFSET_W-1:0]  r_offset;
    logic [OFFSET_W-1:0]  w_offset;
    logic [OFFSET_W-1:0]  w_scroll_h;
    logic [2:0]           w_bar;
    logic                 w_tile;
    logic                 w_scroll_tile;

    logic [COLOR_BITS-1:0] w_r;
    logic [COLOR_BITS-1:0] w_g;
    logic [COLOR_BITS-1:0] w_b;
    logic [COLOR_BITS-1:0] r_red;
    logic [COLOR_BITS-1:0] r_green;
    logic [COLOR_BITS-1:0] r_blue;

    vga_timing #(
        .H_ACTIVE        (H_ACTIVE),
        .H_FP            (H_FP),
        .H_SYNC          (H_SYNC),
        .H_BP            (H_BP),
        .V_ACTIVE        (V_ACTIVE),
        .V_FP            (V_FP),
        .V_SYNC          (V_SYNC),
        .V_BP            (V_BP),
        .SYNC_ACTIVE_LOW (SYNC_ACTIVE_LOW),
        .HW              (HW),
        .VW              (VW)
    ) u_timing (
        .clk            (clk),
        .rst            (rst),
        .o_h_cnt        (w_h_cnt),
        .o_v_cnt        (w_v_cnt),
        .o_active       (w_active),
        .o_frame_origin (w_origin),
        .o_hsync        (vif.hsync),
        .o_vsync        (vif.vsync),
        .o_de           (vif.de),
        .o_frame_start  (vif.frame_start)
    );

    // Controls are taken at the frame origin so the origin pixel already uses the new frame's settings.
    assign w_mode   = w_origin ? mode_e'(vif.mode) : r_mode;
    assign w_speed  = w_origin ? vif.speed : r_speed;
    assign w_offset = (w_origin && (w_mode == MODE_SCROLL)) ? r_offset + OFFSET_W'(w_speed) : r_offset;

    assign w_scroll_h    = OFFSET_W'(w_h_cnt) + w_offset;
    assign w_tile        = w_h_cnt[TILE_LOG2] ^ w_v_cnt[TILE_LOG2];
    assign w_scroll_tile = w_scroll_h[TILE_LOG2] ^ w_v_cnt[TILE_LOG2];
    assign w_bar         = bar_index(16'(w_h_cnt), 16'(BAR_W));

`ifdef VGA_PATTERN_BORDER_EN
    logic w_edge;
    assign w_edge = (w_h_cnt == '0) || (w_h_cnt == HW'(H_ACTIVE - 1)) ||
                    (w_v_cnt == '0) || (w_v_cnt == VW'(V_ACTIVE - 1));
`endif

    always_comb begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
        case (w_mode)
            MODE_SOLID: begin
                w_r = C_MAX;
                w_g = C_MAX;
                w_b = C_MAX;
            end
            MODE_CHECKER: begin
                w_r = {COLOR_BITS{w_tile}};
                w_g = {COLOR_BITS{w_tile}};
                w_b = {COLOR_BITS{w_tile}};
            end
            MODE_BARS: begin
                w_r = {COLOR_BITS{w_bar[2]}};
                w_g = {COLOR_BITS{w_bar[1]}};
                w_b = {COLOR_BITS{w_bar[0]}};
            end
            default: begin
                w_r = {COLOR_BITS{w_scroll_tile}};
                w_g = {COLOR_BITS{w_scroll_tile}};
                w_b = {COLOR_BITS{w_scroll_tile}};
            end
        endcase
`ifdef VGA_PATTERN_BORDER_EN
        if (w_edge) begin
            w_r = C_MAX;
            w_g = C_MAX;
            w_b = C_MAX;
        end
`endif
        if (!w_active) begin
            w_r = '0;
            w_g = '0;
            w_b = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode   <= MODE_SOLID;
            r_speed  <= '0;
            r_offset <= '0;
            r_red    <= '0;
            r_green  <= '0;
            r_blue   <= '0;
        end else begin
            r_mode   <= w_mode;
            r_speed  <= w_speed;
            r_offset <= w_offset;
            r_red    <= w_r;
            r_green  <= w_g;
            r_blue   <= w_b;
        end
    end

    assign vif.red   = r_red;
    assign vif.green = r_green;
    assign vif.blue  = r_blue;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - directed self-checking bench for vga_pattern_gen on a reduced 80x56 raster
module tb_vga_pattern_gen;
    localparam int H_ACTIVE = 64;
    localparam int H_FP     = 4;
    localparam int H_SYNC   = 8;
    localparam int H_BP     = 4;
    localparam int V_ACTIVE = 48;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 4;
    localparam int H_TOT    = 80;
    localparam int FRAME    = 80 * 56;
`ifdef VGA_PATTERN_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [5:0] w_rgb;

    vga_pattern_gen_if #(.COLOR_BITS(2)) vif ();

    vga_pattern_gen #(
        .H_ACTIVE        (H_ACTIVE),
        .H_FP            (H_FP),
        .H_SYNC          (H_SYNC),
        .H_BP            (H_BP),
        .V_ACTIVE        (V_ACTIVE),
        .V_FP            (V_FP),
        .V_SYNC          (V_SYNC),
        .V_BP            (V_BP),
        .COLOR_BITS      (2),
        .TILE_LOG2       (3),
        .SYNC_ACTIVE_LOW (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .vif (vif)
    );

    always #5 clk = ~clk;
    assign w_rgb = {vif.red, vif.green, vif.blue};

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = -1;
    int hs_fall0, hs_fall1, hs_low, vs_first, vs_low, fs_cnt, de_cnt, blank_bad, act_bad;
    logic prev_hs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_pix(input int f, input int v, input int h);
        int target;
        target = f * FRAME + v * H_TOT + h;
        while (cyc < target) step();
    endtask

    function automatic logic [5:0] px(input int h, input int v, input logic [5:0] val);
        if (BORDER && (h == 0 || h == H_ACTIVE - 1 || v == 0 || v == V_ACTIVE - 1))
            return 6'h3F;
        return val;
    endfunction

    task automatic pix(input string tag, input int f, input int v, input int h, input logic [5:0] val);
        wait_pix(f, v, h);
        check(tag, 32'(w_rgb), 32'(px(h, v, val)));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_hsync"}, 32'(vif.hsync), 32'd1);
        check({tag, "_vsync"}, 32'(vif.vsync), 32'd1);
        check({tag, "_de"}, 32'(vif.de), 32'd0);
        check({tag, "_rgb"}, 32'(w_rgb), 32'd0);
        check({tag, "_fs"}, 32'(vif.frame_start), 32'd0);
    endtask

    initial begin
        vif.mode  = 2'd0;
        vif.speed = 4'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;
        cyc = -1;

        // Frame 0, solid: scan every cycle for timing; mode 1 requested mid-frame.
        hs_fall0 = -1; hs_fall1 = -1; hs_low = 0; vs_first = -1; vs_low = 0;
        fs_cnt = 0; de_cnt = 0; blank_bad = 0; act_bad = 0; prev_hs = 1'b1;
        for (int k = 0; k < FRAME; k++) begin
            step();
            if (k == 2000) vif.mode = 2'd1;
            if (!vif.hsync) begin
                hs_low++;
                if (prev_hs && hs_fall0 < 0) hs_fall0 = k;
                else if (prev_hs && hs_fall1 < 0) hs_fall1 = k;
            end
            prev_hs = vif.hsync;
            if (!vif.vsync) begin
                vs_low++;
                if (vs_first < 0) vs_first = k;
            end
            if (vif.frame_start) fs_cnt++;
            if (vif.de) begin
                de_cnt++;
                if (w_rgb != 6'h3F) act_bad++;
            end else if (w_rgb != 6'h00) begin
                blank_bad++;
            end
        end
        check("hsync_first_fall", 32'(hs_fall0), 32'd68);
        check("line_period", 32'(hs_fall1 - hs_fall0), 32'd80);
        check("hsync_low_cycles", 32'(hs_low), 32'd448);
        check("vsync_first", 32'(vs_first), 32'd4000);
        check("vsync_low_cycles", 32'(vs_low), 32'd160);
        check("frame_start_count", 32'(fs_cnt), 32'd1);
        check("de_count", 32'(de_cnt), 32'd3072);
        check("blank_colour_nonzero", 32'(blank_bad), 32'd0);
        check("solid_frame_not_max", 32'(act_bad), 32'd0);

        // Frame 1, checker (8 px tiles); bars requested mid-frame.
        wait_pix(1, 0, 0);
        check("f1_frame_start", 32'(vif.frame_start), 32'd1);
        check("f1_rgb_0_0", 32'(w_rgb), 32'(px(0, 0, 6'h00)));
        pix("f1_chk_1_1", 1, 1, 1, 6'h00);
        pix("f1_chk_9_1", 1, 1, 9, 6'h3F);
        pix("f1_chk_1_9", 1, 9, 1, 6'h3F);
        pix("f1_chk_9_9", 1, 9, 9, 6'h00);
        wait_pix(1, 20, 30);
        vif.mode = 2'd2;
        pix("f1_still_checker", 1, 30, 40, 6'h00);

        // Frame 2, colour bars 8 px wide; scroll at speed 4 requested mid-frame.
        pix("f2_bar0", 2, 5, 1, 6'h00);
        pix("f2_bar1", 2, 5, 8, 6'h03);
        pix("f2_bar2", 2, 5, 20, 6'h0C);
        pix("f2_bar5", 2, 5, 47, 6'h33);
        pix("f2_bar7", 2, 5, 62, 6'h3F);
        wait_pix(2, 5, 64);
        check("f2_blank_rgb", 32'(w_rgb), 32'd0);
        check("f2_blank_de", 32'(vif.de), 32'd0);
        vif.mode  = 2'd3;
        vif.speed = 4'd4;

        // Frame 3 offset 4, frame 4 offset 8.
        pix("f3_scr_0_0", 3, 0, 0, 6'h00);
        pix("f3_scr_4_0", 3, 0, 4, 6'h3F);
        pix("f3_scr_1_1", 3, 1, 1, 6'h00);
        pix("f3_scr_3_1", 3, 1, 3, 6'h00);
        pix("f3_scr_4_1", 3, 1, 4, 6'h3F);
        pix("f4_scr_0_1", 4, 1, 0, 6'h3F);
        pix("f4_scr_4_1", 4, 1, 4, 6'h3F);
        pix("f4_scr_5_1", 4, 1, 5, 6'h3F);
        pix("f4_scr_8_1", 4, 1, 8, 6'h00);
        vif.mode = 2'd0;

        // Frame 5 solid (offset must hold at 8); frame 6 scroll resumes at offset 12.
        pix("f5_solid", 5, 10, 10, 6'h3F);
        vif.mode = 2'd3;
        pix("f6_scr_1_1", 6, 1, 1, 6'h3F);
        pix("f6_scr_4_1", 6, 1, 4, 6'h00);
        pix("f6_scr_2_2", 6, 2, 2, 6'h3F);

        // One-cycle reset mid-frame; next frame restarts from offset 0 + 4.
        wait_pix(6, 20, 30);
        check("pre_reset_de", 32'(vif.de), 32'd1);
        rst = 1'b1;
        step();
        check_reset_state("midreset");
        rst = 1'b0;
        cyc = -1;
        wait_pix(0, 0, 0);
        check("post_reset_fs", 32'(vif.frame_start), 32'd1);
        check("post_reset_rgb_0_0", 32'(w_rgb), 32'(px(0, 0, 6'h00)));
        pix("post_reset_1_1", 0, 1, 1, 6'h00);
        pix("post_reset_4_1", 0, 1, 4, 6'h3F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 SHALL have parameters: H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48 (pixel counts); V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33 (line counts).
REQ-002 SHALL have parameters: COLOR_BITS 2 (bits per channel), TILE_LOG2 5 (checker tile = 2^TILE_LOG2 px), SYNC_ACTIVE_LOW 1 (sync polarity).
REQ-003 SHALL have ports: clk  in  1  pixel clock, sole clock.
REQ-004 SHALL have ports: rst  in  1  synchronous active-high reset.
REQ-005 SHALL have ports: mode  in  2  pattern select (0 solid, 1 checker, 2 colour bars, 3 scrolling checker).
REQ-006 SHALL have ports: speed  in  4  scroll pixels per frame in mode 3.
REQ-007 SHALL have ports: hsync, vsync  out  1 each  syncs, polarity per SYNC_ACTIVE_LOW.
REQ-008 SHALL have ports: red, green, blue  out  COLOR_BITS each  pixel colour.
REQ-009 SHALL have ports: de  out  1  active-video flag; frame_start  out  1  one-cycle pulse.

Function
REQ-010 SHALL count h_cnt 0..H_TOTAL-1, H_TOTAL = sum of H params, wrapping to 0; v_cnt SHALL increment on h_cnt wrap and wrap to 0 at V_TOTAL-1.
REQ-011 SHALL assert hsync for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], vsync for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
REQ-012 SHALL set de for h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; red/green/blue SHALL be 0 whenever de=0.
REQ-013 SHALL register all outputs with a fixed latency of 1 clk relative to (h_cnt,v_cnt); syncs, de and colour SHALL stay mutually aligned.
REQ-014 SHALL pulse frame_start for exactly one cycle when the (1-clk-delayed) counter pair equals (0,0).
REQ-015 SHALL sample mode and speed only at h_cnt=0,v_cnt=0; mid-frame changes take effect on the next frame.
REQ-016 Mode 0 SHALL output all channels at maximum (all ones).
REQ-017 Mode 1 SHALL output max colour when bit TILE_LOG2 of (h_cnt XOR v_cnt) is 1, else 0.
REQ-018 Mode 2 SHALL split H_ACTIVE into 8 bars of H_ACTIVE/8 px; bar index i SHALL map to {r,g,b} = {i[2],i[1],i[0]} each replicated to COLOR_BITS.
REQ-019 Mode 3 SHALL use mode-1 rule on (h_cnt+offset); offset, width 11, SHALL advance by latched speed once per frame at frame start, wrapping mod 2048.
REQ-020 Offset SHALL hold its value in modes 0-2 and resume from it on return to mode 3.

Reset
REQ-021 On rst=1 at a clk edge: h_cnt, v_cnt, offset=0; de=0; colour=0; frame_start=0; hsync/vsync inactive (1 if SYNC_ACTIVE_LOW else 0); latched mode=0, speed=0.
REQ-022 Reset asserted mid-line or mid-frame SHALL take priority over all counting; first cycle after release SHALL process counter pair (0,0).

Configuration
REQ-023 With VGA_PATTERN_BORDER_EN defined, pixels with h_cnt in {0,H_ACTIVE-1} or v_cnt in {0,V_ACTIVE-1} SHALL be max colour in every mode.
REQ-024 Without VGA_PATTERN_BORDER_EN, edge pixels SHALL follow the selected mode; no border logic SHALL be synthesised.

Structure
REQ-025 Package vga_pkg SHALL hold the default 640x480@60 timing constants and the mode encoding constants.
REQ-026 Counters and sync/de generation SHALL live in sub-module vga_timing; pattern logic and output registers in vga_pattern_gen.

Verification
REQ-027 Reset release, defaults -> hsync low for exactly 96 clk starting 657 clk after release; line period 800 clk.
REQ-028 Run one frame -> vsync low for 2 lines (1600 clk); frame period 420000 clk; frame_start once per frame.
REQ-029 mode=1, TILE_LOG2=5 -> line 0: pixels 0-31 black, 32-63 max; line 32 inverted.
REQ-030 mode=3, speed=4 -> frame N+1 line 0 pattern equals frame N shifted 4 px; offset 2044+4 wraps to 0.
REQ-031 Change mode 1->2 at pixel 300 of line 100 -> current frame stays checker; next frame shows 8 bars of 80 px (bar 7 white).
REQ-032 Assert rst for 1 clk mid-frame -> outputs take reset values next cycle; with VGA_PATTERN_BORDER_EN, pixel (0,0) of first frame is max colour.
